// File: rtl/oscope_pkg.sv
// Shared definitions for the oscilloscope capture front end.
//   cap_state_e   : capture FSM states
//   SLOPE_*       : encodings of the trig_rising input
//   frame_len()   : number of adc_clk slots in one ADC conversion frame
package oscope_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } cap_state_e;

   localparam logic SLOPE_FALLING = 1'b0;
   localparam logic SLOPE_RISING  = 1'b1;

   // One conv-high slot each side of the lead-in and data slots.
   function automatic int frame_len(input int lead_cycles, input int adc_bits);
      return lead_cycles + adc_bits + 2;
   endfunction

endpackage

// File: rtl/adc_serial_rx.sv
// Serial ADC frame generator and sample assembler.
//   clk          : oscillator clock
//   reset        : asynchronous, active-high
//   adc_data     : serial data from the ADC, MSB first
//   adc_clk      : ADC serial clock (divider bit CLK_DIV_LOG2-1)
//   adc_conv     : conversion strobe, high in the first and last frame slot
//   sample_valid : one-cycle pulse when sample is updated
//   sample       : top SAMPLE_BITS of the last conversion
//   led          : heartbeat, divider bit LED_BIT
module adc_serial_rx
   import oscope_pkg::*;
#(
   parameter int ADC_BITS     = 12,
   parameter int SAMPLE_BITS  = 8,
   parameter int LEAD_CYCLES  = 2,
   parameter int CLK_DIV_LOG2 = 5,
   parameter int LED_BIT      = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   adc_data,
   output logic                   adc_clk,
   output logic                   adc_conv,
   output logic                   sample_valid,
   output logic [SAMPLE_BITS-1:0] sample,
   output logic                   led
);

   localparam int FRAME  = frame_len(LEAD_CYCLES, ADC_BITS);
   localparam int SLOT_W = $clog2(FRAME);
   localparam int DIV_W  = ((LED_BIT > CLK_DIV_LOG2) ? LED_BIT : CLK_DIV_LOG2) + 1;

   // Divider phase one cycle before adc_clk rises.
   localparam logic [CLK_DIV_LOG2-1:0] TICK_PHASE = CLK_DIV_LOG2'((1 << (CLK_DIV_LOG2 - 1)) - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME - 1);
   localparam logic [SLOT_W-1:0] DATA_FIRST = SLOT_W'(LEAD_CYCLES + 1);
   localparam logic [SLOT_W-1:0] DATA_LAST  = SLOT_W'(LEAD_CYCLES + ADC_BITS);

   logic [DIV_W-1:0]       div_q, div_d;
   logic [SLOT_W-1:0]      slot_q, slot_d;
   logic [ADC_BITS-1:0]    shift_q, shift_d;
   logic [SAMPLE_BITS-1:0] sample_q, sample_d;
   logic                   valid_q, valid_d;
   logic                   conv_q, conv_d;
   logic                   tick_s;
   logic                   in_data_s;

   assign tick_s    = (div_q[CLK_DIV_LOG2-1:0] == TICK_PHASE);
   assign in_data_s = (slot_q >= DATA_FIRST) && (slot_q <= DATA_LAST);

   // Next-state for divider, frame slot, shifter and sample output.
   always_comb begin
      div_d    = div_q + DIV_W'(1'b1);
      slot_d   = slot_q;
      shift_d  = shift_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      if (tick_s) begin
         if (slot_q == SLOT_LAST) begin
            slot_d = {SLOT_W{1'b0}};
         end else begin
            slot_d = slot_q + SLOT_W'(1'b1);
         end
         if (in_data_s) begin
            shift_d = {shift_q[ADC_BITS-2:0], adc_data};
         end else begin
            shift_d = shift_q;
         end
         // The last data bit lands on this tick; publish as slot F-1 begins.
         if (slot_q == DATA_LAST) begin
            sample_d = shift_d[ADC_BITS-1 -: SAMPLE_BITS];
            valid_d  = 1'b1;
         end else begin
            sample_d = sample_q;
            valid_d  = 1'b0;
         end
      end else begin
         slot_d = slot_q;
      end
      conv_d = (slot_d == {SLOT_W{1'b0}}) || (slot_d == SLOT_LAST);
   end

   // Frame and sample registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q    <= {DIV_W{1'b0}};
         slot_q   <= {SLOT_W{1'b0}};
         shift_q  <= {ADC_BITS{1'b0}};
         sample_q <= {SAMPLE_BITS{1'b0}};
         valid_q  <= 1'b0;
         conv_q   <= 1'b1;
      end else begin
         div_q    <= div_d;
         slot_q   <= slot_d;
         shift_q  <= shift_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         conv_q   <= conv_d;
      end
   end

   assign adc_clk      = div_q[CLK_DIV_LOG2-1];
   assign led          = div_q[LED_BIT];
   assign adc_conv     = conv_q;
   assign sample_valid = valid_q;
   assign sample       = sample_q;

endmodule

// File: rtl/oscope_capture.sv
// Scope front end: serial ADC receiver, decimator, triggered ring-buffer
// capture with pre-trigger history, and trigger-relative read port.
//   osc_clk, reset         : clock and asynchronous active-high reset
//   adc_data/clk/conv      : serial ADC interface
//   sample_valid, sample   : live sample stream
//   arm, trig_*, decim     : capture control
//   capturing, triggered, data_ready : capture status
//   rd_en, rd_addr, rd_data: read port, rd_addr 0 = oldest stored sample
//   led                    : heartbeat
module oscope_capture
   import oscope_pkg::*;
#(
   parameter int ADC_BITS     = 12,
   parameter int SAMPLE_BITS  = 8,
   parameter int LEAD_CYCLES  = 2,
   parameter int CLK_DIV_LOG2 = 5,
   parameter int DEPTH        = 8192,
   parameter int PRETRIG      = 4096,
   parameter int LED_BIT      = 23,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic                   osc_clk,
   input  logic                   reset,
   input  logic                   adc_data,
   output logic                   adc_clk,
   output logic                   adc_conv,
   output logic                   sample_valid,
   output logic [SAMPLE_BITS-1:0] sample,
   input  logic                   arm,
   input  logic [SAMPLE_BITS-1:0] trig_level,
   input  logic                   trig_rising,
   input  logic                   trig_auto,
   input  logic [3:0]             decim,
   output logic                   capturing,
   output logic                   triggered,
   output logic                   data_ready,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [SAMPLE_BITS-1:0] rd_data,
   output logic                   led
);

   localparam bit              PRE_EMPTY = (PRETRIG == 0);
   localparam bit              REM_ZERO  = (DEPTH - PRETRIG - 1 == 0);
   localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_EMPTY ? 0 : PRETRIG - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRETRIG);
   localparam logic [ADDR_W-1:0] REM_INIT = ADDR_W'(DEPTH - PRETRIG - 1);

   cap_state_e             state_q, state_d;
   logic [3:0]             decim_q, decim_d;
   logic [3:0]             dec_cnt_q, dec_cnt_d;
   logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]      trig_ptr_q, trig_ptr_d;
   logic [ADDR_W-1:0]      remaining_q, remaining_d;
   logic [SAMPLE_BITS-1:0] prev_q, prev_d;
   logic                   prev_valid_q, prev_valid_d;
   logic                   triggered_q, triggered_d;
   logic                   capturing_q, capturing_d;
   logic                   data_ready_q, data_ready_d;
   logic [SAMPLE_BITS-1:0] rd_data_q;
   logic [SAMPLE_BITS-1:0] mem [DEPTH];

   logic                   accept_s;
   logic                   wr_en_s;
   logic                   rising_hit_s, falling_hit_s, trig_hit_s;
   logic [ADDR_W-1:0]      rd_phys_s;

   adc_serial_rx #(
      .ADC_BITS     (ADC_BITS),
      .SAMPLE_BITS  (SAMPLE_BITS),
      .LEAD_CYCLES  (LEAD_CYCLES),
      .CLK_DIV_LOG2 (CLK_DIV_LOG2),
      .LED_BIT      (LED_BIT)
   ) u_rx (
      .clk          (osc_clk),
      .reset        (reset),
      .adc_data     (adc_data),
      .adc_clk      (adc_clk),
      .adc_conv     (adc_conv),
      .sample_valid (sample_valid),
      .sample       (sample),
      .led          (led)
   );

   // An arm in the same cycle as a sample wins and the sample is dropped.
   assign accept_s  = sample_valid && (dec_cnt_q == 4'd0) && !arm;
   assign rd_phys_s = trig_ptr_q - PRE_OFS + rd_addr;

   // Trigger condition on the incoming sample against the last stored one.
   always_comb begin
      rising_hit_s  = 1'b0;
      falling_hit_s = 1'b0;
      trig_hit_s    = 1'b0;
      if (prev_valid_q) begin
         rising_hit_s  = (prev_q < trig_level) && (sample >= trig_level);
         falling_hit_s = (prev_q > trig_level) && (sample <= trig_level);
      end else begin
         rising_hit_s  = 1'b0;
         falling_hit_s = 1'b0;
      end
      if (trig_auto) begin
         trig_hit_s = 1'b1;
      end else if (trig_rising == SLOPE_RISING) begin
         trig_hit_s = rising_hit_s;
      end else begin
         trig_hit_s = falling_hit_s;
      end
   end

   // Decimator and capture FSM next-state.
   always_comb begin
      state_d      = state_q;
      decim_d      = decim_q;
      dec_cnt_d    = dec_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      trig_ptr_d   = trig_ptr_q;
      remaining_d  = remaining_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      triggered_d  = triggered_q;
      wr_en_s      = 1'b0;

      if (arm) begin
         decim_d   = decim;
         dec_cnt_d = 4'd0;
      end else if (sample_valid) begin
         if (dec_cnt_q == 4'd0) begin
            dec_cnt_d = decim_q;
         end else begin
            dec_cnt_d = dec_cnt_q - 4'd1;
         end
      end else begin
         dec_cnt_d = dec_cnt_q;
      end

      if (arm) begin
         state_d      = PRE_EMPTY ? ST_ARMED : ST_PRE;
         wr_ptr_d     = {ADDR_W{1'b0}};
         prev_valid_d = 1'b0;
         triggered_d  = 1'b0;
      end else if (accept_s) begin
         case (state_q)
            ST_PRE: begin
               wr_en_s      = 1'b1;
               wr_ptr_d     = wr_ptr_q + ADDR_W'(1'b1);
               prev_d       = sample;
               prev_valid_d = 1'b1;
               if (wr_ptr_q == PRE_LAST) begin
                  state_d = ST_ARMED;
               end else begin
                  state_d = ST_PRE;
               end
            end
            ST_ARMED: begin
               wr_en_s      = 1'b1;
               wr_ptr_d     = wr_ptr_q + ADDR_W'(1'b1);
               prev_d       = sample;
               prev_valid_d = 1'b1;
               if (trig_hit_s) begin
                  trig_ptr_d  = wr_ptr_q;
                  triggered_d = 1'b1;
                  remaining_d = REM_INIT;
                  state_d     = REM_ZERO ? ST_DONE : ST_POST;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_POST: begin
               wr_en_s      = 1'b1;
               wr_ptr_d     = wr_ptr_q + ADDR_W'(1'b1);
               prev_d       = sample;
               prev_valid_d = 1'b1;
               remaining_d  = remaining_q - ADDR_W'(1'b1);
               if (remaining_q == ADDR_W'(1'b1)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_POST;
               end
            end
            ST_IDLE, ST_DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      capturing_d  = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
      data_ready_d = (state_d == ST_DONE);
   end

   // Capture control and status registers.
   always_ff @(posedge osc_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         decim_q      <= 4'd0;
         dec_cnt_q    <= 4'd0;
         wr_ptr_q     <= {ADDR_W{1'b0}};
         trig_ptr_q   <= {ADDR_W{1'b0}};
         remaining_q  <= {ADDR_W{1'b0}};
         prev_q       <= {SAMPLE_BITS{1'b0}};
         prev_valid_q <= 1'b0;
         triggered_q  <= 1'b0;
         capturing_q  <= 1'b0;
         data_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         decim_q      <= decim_d;
         dec_cnt_q    <= dec_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         trig_ptr_q   <= trig_ptr_d;
         remaining_q  <= remaining_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         triggered_q  <= triggered_d;
         capturing_q  <= capturing_d;
         data_ready_q <= data_ready_d;
      end
   end

   // Sample buffer write port; contents survive reset.
   always_ff @(posedge osc_clk) begin
      if (wr_en_s) begin
         mem[wr_ptr_q] <= sample;
      end
   end

   // Registered read port, kept beside the RAM so it maps to the RAM output register.
   always_ff @(posedge osc_clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= {SAMPLE_BITS{1'b0}};
      end else if (rd_en) begin
         rd_data_q <= mem[rd_phys_s];
      end
   end

   assign capturing  = capturing_q;
   assign triggered  = triggered_q;
   assign data_ready = data_ready_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_oscope_capture.sv
// Directed bench for oscope_capture: one default-parameter instance for frame
// timing and one small instance (DEPTH 16, PRETRIG 4, fast adc_clk) for capture.
module tb_oscope_capture;

   localparam int ADC_BITS = 12;
   localparam int LEAD     = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   // Cycle counter for interval measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // default-parameter instance
   logic       d_adc_data = 1'b0;
   logic       d_adc_clk, d_adc_conv, d_sample_valid, d_capturing, d_triggered, d_data_ready, d_led;
   logic [7:0] d_sample, d_rd_data;

   // small capture instance
   logic       s_adc_data = 1'b0;
   logic       s_adc_clk, s_adc_conv, s_sample_valid, s_capturing, s_triggered, s_data_ready, s_led;
   logic [7:0] s_sample, s_rd_data;
   logic       arm = 1'b0;
   logic [7:0] trig_level = 8'h80;
   logic       trig_rising = 1'b1;
   logic       trig_auto = 1'b0;
   logic [3:0] decim = 4'd0;
   logic       rd_en = 1'b0;
   logic [3:0] rd_addr = 4'd0;

   logic [11:0] word_q [$];
   logic [11:0] s_word = 12'h000;
   int          s_fcnt = 0;
   int          d_fcnt = 0;
   logic [11:0] d_word = 12'hA5C;

   oscope_capture u_dut_def (
      .osc_clk(clk), .reset(reset), .adc_data(d_adc_data),
      .adc_clk(d_adc_clk), .adc_conv(d_adc_conv),
      .sample_valid(d_sample_valid), .sample(d_sample),
      .arm(1'b0), .trig_level(8'h80), .trig_rising(1'b1), .trig_auto(1'b0), .decim(4'd0),
      .capturing(d_capturing), .triggered(d_triggered), .data_ready(d_data_ready),
      .rd_en(1'b0), .rd_addr(13'd0), .rd_data(d_rd_data), .led(d_led)
   );

   oscope_capture #(.CLK_DIV_LOG2(2), .DEPTH(16), .PRETRIG(4)) u_dut (
      .osc_clk(clk), .reset(reset), .adc_data(s_adc_data),
      .adc_clk(s_adc_clk), .adc_conv(s_adc_conv),
      .sample_valid(s_sample_valid), .sample(s_sample),
      .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising), .trig_auto(trig_auto), .decim(decim),
      .capturing(s_capturing), .triggered(s_triggered), .data_ready(s_data_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s_rd_data), .led(s_led)
   );

   // ADC model for the default instance: constant word every frame.
   initial begin
      forever begin
         @(negedge d_adc_clk);
         if (d_adc_conv) begin
            d_fcnt = 0;
         end else begin
            d_fcnt++;
            if (d_fcnt >= LEAD + 1 && d_fcnt <= LEAD + ADC_BITS) d_adc_data = d_word[ADC_BITS - 1 - (d_fcnt - LEAD - 1)];
            else d_adc_data = 1'b0;
         end
      end
   end

   // ADC model for the small instance: one queued word per frame.
   initial begin
      forever begin
         @(negedge s_adc_clk);
         if (s_adc_conv) begin
            s_fcnt = 0;
         end else begin
            s_fcnt++;
            if (s_fcnt == LEAD + 1) begin
               if (word_q.size() > 0) s_word = word_q.pop_front();
               else s_word = 12'h000;
            end
            if (s_fcnt >= LEAD + 1 && s_fcnt <= LEAD + ADC_BITS) s_adc_data = s_word[ADC_BITS - 1 - (s_fcnt - LEAD - 1)];
            else s_adc_data = 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait for n small-instance samples, then one more cycle so the FSM has consumed the last.
   task automatic wait_samples(input int n, input string tag);
      int seen = 0;
      int budget = n * 100 + 10;
      while (seen < n && budget > 0) begin
         @(posedge clk); #1;
         if (s_sample_valid) seen++;
         budget--;
      end
      if (seen < n) check_eq(tag, 32'(seen), 32'(n));
      @(posedge clk); #1;
   endtask

   task automatic wait_dvalid(input string tag, output int when);
      int b = 2000;
      @(posedge clk); #1;
      while (!d_sample_valid && b > 0) begin
         @(posedge clk); #1;
         b--;
      end
      if (!d_sample_valid) check_eq(tag, 32'(d_sample_valid), 32'd1);
      when = cyc;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic rd_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
      rd_en = 1'b1;
      rd_addr = a;
      @(posedge clk); #1;
      rd_en = 1'b0;
      check_eq(tag, 32'(s_rd_data), 32'(exp));
   endtask

   task automatic push_ramp(input int first, input int count, input int step);
      for (int k = 0; k < count; k++) word_q.push_back({8'(first + k * step), 4'h5});
   endtask

   // Hard stop if something stalls beyond every per-wait bound.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, lowcnt, b;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_adc_clk", 32'(s_adc_clk), 32'd0);
      check_eq("rst_adc_conv", 32'(s_adc_conv), 32'd1);
      check_eq("rst_valid", 32'(s_sample_valid), 32'd0);
      check_eq("rst_sample", 32'(s_sample), 32'd0);
      check_eq("rst_capturing", 32'(s_capturing), 32'd0);
      check_eq("rst_triggered", 32'(s_triggered), 32'd0);
      check_eq("rst_data_ready", 32'(s_data_ready), 32'd0);
      check_eq("rst_rd_data", 32'(s_rd_data), 32'd0);
      check_eq("rst_led", 32'(d_led), 32'd0);
      reset = 1'b0;

      // frame timing with default parameters
      wait_dvalid("frame_v0", t0);
      check_eq("frame_sample0", 32'(d_sample), 32'hA5);
      wait_dvalid("frame_v1", t1);
      check_eq("frame_period", 32'(t1 - t0), 32'd512);
      check_eq("frame_sample1", 32'(d_sample), 32'hA5);
      b = 2000;
      while (d_adc_conv && b > 0) begin @(posedge clk); #1; b--; end
      lowcnt = 0;
      while (!d_adc_conv && lowcnt < 2000) begin @(posedge clk); #1; lowcnt++; end
      check_eq("conv_low_len", 32'(lowcnt), 32'd448);

      // auto trigger: samples 1,2,3,...
      trig_auto = 1'b1;
      wait_samples(1, "auto_sync");
      word_q.delete();
      push_ramp(1, 20, 1);
      arm_pulse();
      check_eq("auto_capturing", 32'(s_capturing), 32'd1);
      wait_samples(4, "auto_w4");
      check_eq("auto_not_trig_4", 32'(s_triggered), 32'd0);
      wait_samples(1, "auto_w5");
      check_eq("auto_trig_5", 32'(s_triggered), 32'd1);
      wait_samples(10, "auto_w15");
      check_eq("auto_not_ready_15", 32'(s_data_ready), 32'd0);
      wait_samples(1, "auto_w16");
      check_eq("auto_ready_16", 32'(s_data_ready), 32'd1);
      check_eq("auto_done_idle", 32'(s_capturing), 32'd0);
      for (int i = 0; i < 16; i++) rd_check(4'(i), 8'(i + 1), "auto_rd");

      // rising trigger across a buffer wrap
      trig_auto = 1'b0;
      trig_rising = 1'b1;
      trig_level = 8'h80;
      wait_samples(1, "rise_sync");
      word_q.delete();
      push_ramp(8'h00, 30, 8);
      arm_pulse();
      wait_samples(16, "rise_w16");
      check_eq("rise_not_trig", 32'(s_triggered), 32'd0);
      wait_samples(1, "rise_w17");
      check_eq("rise_trig", 32'(s_triggered), 32'd1);
      wait_samples(11, "rise_w28");
      check_eq("rise_ready", 32'(s_data_ready), 32'd1);
      rd_check(4'd0, 8'h60, "rise_rd0");
      rd_check(4'd3, 8'h78, "rise_rd3");
      rd_check(4'd4, 8'h80, "rise_rd4");
      rd_check(4'd15, 8'hD8, "rise_rd15");

      // falling trigger: 0x90 held, then constant 0x80
      trig_rising = 1'b0;
      wait_samples(1, "fall_sync");
      word_q.delete();
      for (int k = 0; k < 7; k++) word_q.push_back(12'h90F);
      for (int k = 0; k < 14; k++) word_q.push_back(12'h800);
      arm_pulse();
      wait_samples(7, "fall_w7");
      check_eq("fall_not_trig", 32'(s_triggered), 32'd0);
      wait_samples(1, "fall_w8");
      check_eq("fall_trig", 32'(s_triggered), 32'd1);
      wait_samples(11, "fall_w19");
      check_eq("fall_ready", 32'(s_data_ready), 32'd1);
      rd_check(4'd0, 8'h90, "fall_rd0");
      rd_check(4'd3, 8'h90, "fall_rd3");
      rd_check(4'd4, 8'h80, "fall_rd4");
      rd_check(4'd15, 8'h80, "fall_rd15");

      // decimation by 4 with auto trigger; decim is latched on arm only
      trig_auto = 1'b1;
      decim = 4'd3;
      wait_samples(1, "dec_sync");
      word_q.delete();
      push_ramp(1, 70, 1);
      arm_pulse();
      decim = 4'd0;
      wait_samples(16, "dec_w16");
      check_eq("dec_not_trig", 32'(s_triggered), 32'd0);
      wait_samples(1, "dec_w17");
      check_eq("dec_trig", 32'(s_triggered), 32'd1);
      wait_samples(44, "dec_w61");
      check_eq("dec_ready", 32'(s_data_ready), 32'd1);
      rd_check(4'd0, 8'd1, "dec_rd0");
      rd_check(4'd1, 8'd5, "dec_rd1");
      rd_check(4'd4, 8'd17, "dec_rd4");
      rd_check(4'd15, 8'd61, "dec_rd15");

      // reset while in POST aborts at once
      wait_samples(1, "rst_sync");
      word_q.delete();
      push_ramp(1, 30, 1);
      arm_pulse();
      wait_samples(6, "rst_w6");
      check_eq("post_triggered", 32'(s_triggered), 32'd1);
      check_eq("post_capturing", 32'(s_capturing), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      check_eq("pre_rst_conv_low", 32'(s_adc_conv), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_capturing", 32'(s_capturing), 32'd0);
      check_eq("mid_rst_triggered", 32'(s_triggered), 32'd0);
      check_eq("mid_rst_data_ready", 32'(s_data_ready), 32'd0);
      check_eq("mid_rst_conv", 32'(s_adc_conv), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // arm during POST restarts from PRE
      wait_samples(1, "rearm_sync");
      word_q.delete();
      push_ramp(1, 30, 1);
      arm_pulse();
      wait_samples(6, "rearm_w6");
      check_eq("rearm_post_trig", 32'(s_triggered), 32'd1);
      arm_pulse();
      check_eq("rearm_trig_clr", 32'(s_triggered), 32'd0);
      check_eq("rearm_capturing", 32'(s_capturing), 32'd1);
      wait_samples(16, "rearm_w16");
      check_eq("rearm_ready", 32'(s_data_ready), 32'd1);
      rd_check(4'd0, 8'd7, "rearm_rd0");
      rd_check(4'd4, 8'd11, "rearm_rd4");
      rd_check(4'd15, 8'd22, "rearm_rd15");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
